// File: rtl/terrain_ram_arbiter.sv
// Single-port terrain column RAM arbiter: display reads always win the port,
// explosion carves (read-modify-write clear of a row range) use idle cycles.
module terrain_ram_arbiter #(
    parameter int COLS  = 640,
    parameter int ROWS  = 512,
    parameter int COL_W = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             disp_req,
    input  logic [COL_W-1:0] disp_col,
    output logic [ROWS-1:0]  disp_data,
    output logic             disp_valid,
    input  logic             carve_req,
    input  logic [COL_W-1:0] carve_col,
    input  logic [8:0]       carve_y_lo,
    input  logic [8:0]       carve_y_hi,
    output logic             carve_ready,
    output logic             carve_done,
    output logic [COL_W-1:0] ram_addr,
    output logic             ram_we,
    output logic [ROWS-1:0]  ram_wdata,
    input  logic [ROWS-1:0]  ram_rdata,
    output logic [2:0]       carve_state_dbg
);

    // Handshake: a carve is accepted on any cycle where carve_req && carve_ready;
    // carve_col/carve_y_lo/carve_y_hi are sampled only then. disp_req has no back-pressure.
    typedef enum logic [2:0] {
        C_IDLE  = 3'd0,
        C_READ  = 3'd1,
        C_WAIT  = 3'd2,
        C_WRITE = 3'd3,
        C_DONE  = 3'd4
    } carve_state_e;

    localparam logic [COL_W:0] COLS_L = (COL_W+1)'(COLS);

    carve_state_e     state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [8:0]       lo_q, lo_d;
    logic [8:0]       hi_q, hi_d;
    logic [ROWS-1:0]  work_q, work_d;
    logic             disp_p1_q, disp_p1_d;
    logic             disp_valid_q, disp_valid_d;
    logic [ROWS-1:0]  disp_data_q, disp_data_d;
    logic [COL_W-1:0] ram_addr_q, ram_addr_d;
    logic [ROWS-1:0]  mask;
    logic             accept;
    logic             bad_req;

    assign accept  = carve_req && (state_q == C_IDLE);
    assign bad_req = (carve_y_lo > carve_y_hi) || ({1'b0, carve_col} >= COLS_L);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= C_IDLE;
            col_q        <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            work_q       <= '0;
            disp_p1_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            ram_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            work_q       <= work_d;
            disp_p1_q    <= disp_p1_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            ram_addr_q   <= ram_addr_d;
        end
    end

    // Carve next state; READ and WRITE stall while the display owns the port.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        work_d  = work_q;
        case (state_q)
            C_IDLE: begin
                if (accept) begin
                    col_d   = carve_col;
                    lo_d    = carve_y_lo;
                    hi_d    = carve_y_hi;
                    state_d = bad_req ? C_DONE : C_READ;
                end
            end
            C_READ:  if (!disp_req) state_d = C_WAIT;
            C_WAIT: begin
                work_d  = ram_rdata;
                state_d = C_WRITE;
            end
            C_WRITE: if (!disp_req) state_d = C_DONE;
            C_DONE:  state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        mask = '0;
        for (int y = 0; y < ROWS; y++) begin
            mask[y] = (y >= int'(lo_q)) && (y <= int'(hi_q));
        end
    end

    // Port mux and carve status outputs.
    always_comb begin
        ram_we      = 1'b0;
        ram_addr    = ram_addr_q;
        ram_wdata   = work_q & ~mask;
        carve_ready = (state_q == C_IDLE);
        carve_done  = (state_q == C_DONE);
        if (disp_req) begin
            ram_addr = disp_col;
        end else if (state_q == C_READ) begin
            ram_addr = col_q;
        end else if (state_q == C_WRITE) begin
            ram_addr = col_q;
            ram_we   = 1'b1;
        end
    end

    always_comb begin
        ram_addr_d   = ram_addr;
        disp_p1_d    = disp_req;
        disp_valid_d = disp_p1_q;
        disp_data_d  = disp_p1_q ? ram_rdata : disp_data_q;
    end

    assign disp_valid      = disp_valid_q;
    assign disp_data       = disp_data_q;
    assign carve_state_dbg = state_q;

endmodule

// File: tb/tb_terrain_ram_arbiter.sv
// Bench for terrain_ram_arbiter: RAM model, directed scenarios, randomized traffic,
// and a cycle-level behavioural model compared against the DUT every cycle.
module tb_terrain_ram_arbiter;
    localparam int COLS  = 640;
    localparam int ROWS  = 512;
    localparam int COL_W = 10;
    localparam int W     = ROWS;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             disp_req;
    logic [COL_W-1:0] disp_col;
    logic [ROWS-1:0]  disp_data;
    logic             disp_valid;
    logic             carve_req;
    logic [COL_W-1:0] carve_col;
    logic [8:0]       carve_y_lo;
    logic [8:0]       carve_y_hi;
    logic             carve_ready;
    logic             carve_done;
    logic [COL_W-1:0] ram_addr;
    logic             ram_we;
    logic [ROWS-1:0]  ram_wdata;
    logic [ROWS-1:0]  ram_rdata;
    logic [2:0]       carve_state_dbg;

    terrain_ram_arbiter #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .disp_req(disp_req), .disp_col(disp_col), .disp_data(disp_data), .disp_valid(disp_valid),
        .carve_req(carve_req), .carve_col(carve_col), .carve_y_lo(carve_y_lo), .carve_y_hi(carve_y_hi),
        .carve_ready(carve_ready), .carve_done(carve_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .carve_state_dbg(carve_state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 Clk = ~Clk;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- RAM ----------------
    logic [W-1:0] mem  [COLS];
    logic [W-1:0] gold [COLS];
    always @(posedge Clk) begin
        if (ram_we && ram_addr < COLS) mem[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_addr < COLS) ? mem[ram_addr] : '0;
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    int           due_q[$];

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] mk_mask(int lo, int hi);
        logic [W-1:0] ones;
        ones = '1;
        if (lo > hi) return '0;
        return (ones << lo) & (ones >> (W - 1 - hi));
    endfunction

    // ---------------- behavioural model + compare ----------------
    bit               chk_en = 0;
    bit               m_active = 0;
    bit               m_invalid;
    int               m_accept, m_read_at, m_write_at;
    logic [COL_W-1:0] m_col;
    logic [W-1:0]     m_mask;
    logic [COL_W-1:0] m_last_addr = '0;
    int               we_cnt = 0, done_cnt = 0;

    always @(negedge Clk) begin
        logic             exp_we, exp_done, exp_valid, rdy;
        logic [COL_W-1:0] exp_addr;
        logic [W-1:0]     exp_wd;
        if (ram_we) we_cnt++;
        if (carve_done) done_cnt++;
        if (chk_en) begin
            exp_valid = (due_q.size() > 0) && (due_q[0] == cyc);
            chk("disp_valid", W'(disp_valid), W'(exp_valid));
            if (exp_valid) begin
                chk("disp_data", disp_data, exp_q[0]);
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end
            rdy = !m_active;
            chk("carve_ready", W'(carve_ready), W'(rdy));

            exp_we   = 1'b0;
            exp_addr = m_last_addr;
            exp_wd   = '0;
            if (disp_req) begin
                exp_addr = disp_col;
            end else if (m_active && !m_invalid && m_read_at < 0) begin
                exp_addr  = m_col;
                m_read_at = cyc;
            end else if (m_active && !m_invalid && m_write_at < 0 && cyc >= m_read_at + 2) begin
                exp_addr   = m_col;
                exp_we     = 1'b1;
                exp_wd     = gold[m_col] & ~m_mask;
                m_write_at = cyc;
            end
            chk("ram_we", W'(ram_we), W'(exp_we));
            chk("ram_addr", W'(ram_addr), W'(exp_addr));
            if (exp_we) chk("ram_wdata", ram_wdata, exp_wd);
            m_last_addr = exp_addr;
            if (disp_req) begin
                due_q.push_back(cyc + 2);
                exp_q.push_back(gold[disp_col]);
            end
            if (exp_we) gold[m_col] = exp_wd;

            exp_done = m_active && ((m_invalid && cyc == m_accept + 1) ||
                                    (m_write_at >= 0 && cyc == m_write_at + 1));
            chk("carve_done", W'(carve_done), W'(exp_done));
            if (exp_done) m_active = 0;

            if (carve_req && rdy && !Reset) begin
                m_active   = 1;
                m_accept   = cyc;
                m_col      = carve_col;
                m_invalid  = (carve_y_lo > carve_y_hi) || (carve_col >= COLS);
                m_mask     = mk_mask(int'(carve_y_lo), int'(carve_y_hi));
                m_read_at  = -1;
                m_write_at = -1;
            end
            if (Reset) begin
                m_active    = 0;
                m_last_addr = '0;
                due_q.delete();
                exp_q.delete();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_word(input int c, input logic [W-1:0] v);
        mem[c]  = v;
        gold[c] = v;
    endtask

    task automatic run_carve(input logic [COL_W-1:0] col, input logic [8:0] lo, input logic [8:0] hi,
                             input bit alt_disp, input logic [COL_W-1:0] dcol, output int lat);
        int acc_c, k;
        bit got;
        lat = -1;
        carve_req = 1'b1; carve_col = col; carve_y_lo = lo; carve_y_hi = hi;
        got = 0; k = 0; acc_c = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            disp_req = alt_disp && (k % 2 == 0); disp_col = dcol; k++;
            @(negedge Clk);
            if (carve_ready) begin got = 1; acc_c = cyc; end
            tick();
        end
        carve_req = 1'b0;
        if (!got) begin chk("carve_accept_timeout", 0, 1); disp_req = 1'b0; return; end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            disp_req = alt_disp && (k % 2 == 0); k++;
            @(negedge Clk);
            if (carve_done) begin got = 1; lat = cyc - acc_c; end
            tick();
        end
        disp_req = 1'b0;
        if (!got) chk("carve_done_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] w, v3, t6 [4];
        int lat, we0, dn0, run;
        Reset = 1'b1; disp_req = 1'b0; disp_col = '0; carve_req = 1'b0;
        carve_col = '0; carve_y_lo = '0; carve_y_hi = '0;
        for (int i = 0; i < COLS; i++) begin
            for (int j = 0; j < W / 32; j++) w[j*32 +: 32] = $urandom();
            set_word(i, w);
        end
        repeat (3) tick();
        Reset = 1'b0;
        chk_en = 1;
        @(negedge Clk);
        chk("rst_disp_valid", W'(disp_valid), 0);
        chk("rst_disp_data", disp_data, 0);
        chk("rst_carve_done", W'(carve_done), 0);
        chk("rst_ram_we", W'(ram_we), 0);
        chk("rst_carve_ready", W'(carve_ready), 1);
        tick();

        // display read, 2-cycle latency
        set_word(5, '1);
        disp_req = 1'b1; disp_col = 10'd5;
        tick();
        disp_req = 1'b0;
        @(negedge Clk); chk("t1_valid_n1", W'(disp_valid), 0);
        tick();
        @(negedge Clk); chk("t1_valid_n2", W'(disp_valid), 1); chk("t1_data", disp_data, '1);
        tick();
        @(negedge Clk); chk("t1_valid_n3", W'(disp_valid), 0);
        tick();

        // basic carve
        set_word(100, '1);
        run_carve(10'd100, 9'd10, 9'd19, 0, '0, lat);
        chk("t2_latency", W'(lat), 4);
        w = '1;
        for (int y = 10; y <= 19; y++) w[y] = 1'b0;
        tick();
        chk("t2_word", mem[100], w);

        // carve under alternating display traffic on the same column
        we0 = we_cnt;
        run_carve(10'd7, 9'd0, 9'd100, 1, 10'd7, lat);
        repeat (3) tick();
        chk("t3_one_write", W'(we_cnt - we0), 1);

        // no-op carves
        we0 = we_cnt;
        run_carve(10'd50, 9'd30, 9'd20, 0, '0, lat);
        chk("t4_lohi_latency", W'(lat), 1);
        run_carve(10'd700, 9'd0, 9'd5, 0, '0, lat);
        chk("t4_col_latency", W'(lat), 1);
        chk("t4_no_write", W'(we_cnt - we0), 0);

        // reset during C_WAIT
        v3 = mem[3]; we0 = we_cnt; dn0 = done_cnt;
        carve_req = 1'b1; carve_col = 10'd3; carve_y_lo = 9'd0; carve_y_hi = 9'd511;
        tick();
        carve_req = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        @(negedge Clk); chk("t5_ready", W'(carve_ready), 1);
        repeat (6) tick();
        chk("t5_word", mem[3], v3);
        chk("t5_no_write", W'(we_cnt - we0), 0);
        chk("t5_no_done", W'(done_cnt - dn0), 0);

        // back-to-back display reads
        for (int i = 0; i < 4; i++) t6[i] = mem[i];
        for (int i = 0; i < 7; i++) begin
            disp_req = (i < 4); disp_col = COL_W'(i < 4 ? i : 0);
            if (i >= 2) begin
                @(negedge Clk);
                if (i < 6) begin
                    chk("t6_valid", W'(disp_valid), 1);
                    chk("t6_data", disp_data, t6[i-2]);
                end else chk("t6_valid_end", W'(disp_valid), 0);
            end
            tick();
        end

        // randomized traffic, biased to a few hot columns to exercise hazards
        run = 0;
        for (int i = 0; i < 1500; i++) begin
            bit acc;
            disp_req = (run < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            run      = disp_req ? run + 1 : 0;
            disp_col = ($urandom_range(0, 1) == 1) ? COL_W'($urandom_range(0, 3))
                                                   : COL_W'($urandom_range(0, COLS - 1));
            if (!carve_req && $urandom_range(0, 3) == 0) begin
                int lo;
                carve_req  = 1'b1;
                carve_col  = ($urandom_range(0, 7) == 0) ? COL_W'($urandom_range(COLS, 1023))
                                                         : COL_W'($urandom_range(0, 3));
                lo         = $urandom_range(0, 511);
                carve_y_lo = 9'(lo);
                carve_y_hi = ($urandom_range(0, 4) == 0) ? 9'($urandom_range(0, 511))
                                                         : 9'(lo + $urandom_range(0, 511 - lo));
            end
            @(negedge Clk);
            acc = carve_req && carve_ready;
            tick();
            if (acc) carve_req = 1'b0;
        end
        disp_req = 1'b0; carve_req = 1'b0;
        repeat (12) tick();
        chk("drain_queue", W'(due_q.size()), 0);
        chk("drain_idle", W'(carve_ready), 1);
        for (int i = 0; i < 8; i++) chk("final_word", mem[i], gold[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
